// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage with register file, decoder, sign extend, load-use hazard detection and the ID/EX register; define BRANCH_RESOLVE_EN to resolve branches/jumps in ID
//   in : i_clk, i_rst_n (async, active low), i_pc, i_instruction, i_valid, i_flush, i_halt,
//        i_wb_write/addr/data, i_write_debug_reg_file, i_address_write_debug, i_write_data_debug, i_address_read_debug
//   out: o_data_read_debug, o_stall (combinational); o_pc, o_data_1, o_data_2, o_sign_extend, o_rs, o_rt, o_rd,
//        o_funct, o_alu_op, o_ctrl, o_valid (ID/EX registered); o_branch_taken, o_branch_target
module id_stage_pipe #(
  parameter int NB_ADDR  = 32,
  parameter int NB_INST  = 32,
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int NUM_REGS = 32,
  parameter int NB_IMM   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic               i_valid,
  input  logic               i_flush,
  input  logic               i_halt,
  input  logic               i_wb_write,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_write_debug_reg_file,
  input  logic [NB_REG-1:0]  i_address_write_debug,
  input  logic [NB_DATA-1:0] i_write_data_debug,
  input  logic [NB_REG-1:0]  i_address_read_debug,
  output logic [NB_DATA-1:0] o_data_read_debug,
  output logic               o_stall,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_DATA-1:0] o_data_1,
  output logic [NB_DATA-1:0] o_data_2,
  output logic [NB_DATA-1:0] o_sign_extend,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [5:0]         o_funct,
  output logic [1:0]         o_alu_op,
  output logic [7:0]         o_ctrl,
  output logic               o_valid,
  output logic               o_branch_taken,
  output logic [NB_ADDR-1:0] o_branch_target
);
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [NB_REG:0] REG_LIM = (NB_REG+1)'(NUM_REGS);
  logic [NB_DATA-1:0] rf [2**NB_REG];
  logic [5:0] op;
  logic [NB_REG-1:0] rs, rt, rd;
  logic [NB_DATA-1:0] data_1, data_2, sext;
  logic [7:0] ctrl, ex_ctrl;
  logic [1:0] alu_op;
  logic wb_ok, dbg_ok, uses_rt;
  assign op = i_instruction[NB_INST-1 -: 6];
  assign rs = i_instruction[21 +: NB_REG];
  assign rt = i_instruction[16 +: NB_REG];
  assign rd = i_instruction[11 +: NB_REG];
  assign sext = {{(NB_DATA-NB_IMM){i_instruction[NB_IMM-1]}}, i_instruction[NB_IMM-1:0]};
  assign wb_ok = i_wb_write && i_wb_addr != '0 && {1'b0, i_wb_addr} < REG_LIM;
  assign dbg_ok = i_write_debug_reg_file && i_address_write_debug != '0 && {1'b0, i_address_write_debug} < REG_LIM;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rf <= '{default: '0};
    else begin
      if (wb_ok) rf[i_wb_addr] <= i_wb_data;
      if (dbg_ok) rf[i_address_write_debug] <= i_write_data_debug;
    end
  assign data_1 = (i_wb_write && rs != '0 && i_wb_addr == rs) ? i_wb_data : rf[rs];
  assign data_2 = (i_wb_write && rt != '0 && i_wb_addr == rt) ? i_wb_data : rf[rt];
  assign o_data_read_debug = rf[i_address_read_debug];
  always_comb begin
    ctrl = op == OP_R    ? 8'b1000_0001 :
           op == OP_LW   ? 8'b1110_0010 :
           op == OP_SW   ? 8'b0001_0010 :
           op == OP_BEQ  ? 8'b0000_1000 :
           op == OP_BNE  ? 8'b0000_1100 :
           op == OP_ADDI ? 8'b1000_0010 : 8'b0000_0000;
    alu_op = op == OP_R ? 2'b10 : (op == OP_BEQ || op == OP_BNE) ? 2'b01 : 2'b00;
    uses_rt = op == OP_R || op == OP_SW || op == OP_BEQ || op == OP_BNE;
  end
  assign o_stall = i_valid & o_valid & o_ctrl[5] & (o_rt != '0) & ((o_rt == rs) | ((o_rt == rt) & uses_rt)) & ~i_flush;
`ifdef BRANCH_RESOLVE_EN
  logic eq;
  assign eq = data_1 == data_2;
  assign o_branch_taken = i_valid & ~o_stall & ~i_flush & ((op == OP_BEQ & eq) | (op == OP_BNE & ~eq) | (op == OP_J));
  assign o_branch_target = op == OP_J ? {i_pc[NB_ADDR-1:28], i_instruction[25:0], 2'b00} : i_pc + (NB_ADDR'(sext) << 2);
  assign ex_ctrl = ctrl & 8'b1111_0011;
`else
  assign o_branch_taken = 1'b0;
  assign o_branch_target = '0;
  assign ex_ctrl = ctrl;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_pc <= '0;
      o_data_1 <= '0;
      o_data_2 <= '0;
      o_sign_extend <= '0;
      o_rs <= '0;
      o_rt <= '0;
      o_rd <= '0;
      o_funct <= '0;
      o_alu_op <= '0;
      o_ctrl <= '0;
      o_valid <= 1'b0;
    end else if (!i_halt) begin
      if (i_flush || o_stall || !i_valid) begin
        o_pc <= '0;
        o_data_1 <= '0;
        o_data_2 <= '0;
        o_sign_extend <= '0;
        o_rs <= '0;
        o_rt <= '0;
        o_rd <= '0;
        o_funct <= '0;
        o_alu_op <= '0;
        o_ctrl <= '0;
        o_valid <= 1'b0;
      end else begin
        o_pc <= i_pc;
        o_data_1 <= data_1;
        o_data_2 <= data_2;
        o_sign_extend <= sext;
        o_rs <= rs;
        o_rt <= rt;
        o_rd <= rd;
        o_funct <= i_instruction[5:0];
        o_alu_op <= alu_op;
        o_ctrl <= ex_ctrl;
        o_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: table vectors, corner sequences and randomized checks against a reference model
module tb_id_stage_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] pc, instr, wbd, dbwd;
  logic valid, flush, halt, wbw, dbw;
  logic [4:0] wba, dbwa, dbra;
  logic [31:0] dbg_q, q_pc, q_d1, q_d2, q_sx, b_target;
  logic stall, q_valid, b_taken;
  logic [4:0] q_rs, q_rt, q_rd;
  logic [5:0] q_fn;
  logic [1:0] q_alu;
  logic [7:0] q_ctrl;
  id_stage_pipe dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc(pc), .i_instruction(instr), .i_valid(valid),
    .i_flush(flush), .i_halt(halt), .i_wb_write(wbw), .i_wb_addr(wba), .i_wb_data(wbd),
    .i_write_debug_reg_file(dbw), .i_address_write_debug(dbwa), .i_write_data_debug(dbwd),
    .i_address_read_debug(dbra), .o_data_read_debug(dbg_q), .o_stall(stall), .o_pc(q_pc),
    .o_data_1(q_d1), .o_data_2(q_d2), .o_sign_extend(q_sx), .o_rs(q_rs), .o_rt(q_rt), .o_rd(q_rd),
    .o_funct(q_fn), .o_alu_op(q_alu), .o_ctrl(q_ctrl), .o_valid(q_valid),
    .o_branch_taken(b_taken), .o_branch_target(b_target));
  int vecs = 0, errs = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic idle();
    pc = '0; instr = '0; valid = 0; flush = 0; halt = 0;
    wbw = 0; wba = '0; wbd = '0; dbw = 0; dbwa = '0; dbwd = '0; dbra = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  localparam logic [7:0] RW = 8'h80, M2R = 8'h40, MR = 8'h20, MW = 8'h10, BR = 8'h08, BN = 8'h04, AS = 8'h02, RD = 8'h01;
  function automatic logic [9:0] dec(input logic [5:0] op);
    case (op)
      6'h00: return {RW | RD, 2'b10};
      6'h23: return {RW | M2R | MR | AS, 2'b00};
      6'h2b: return {MW | AS, 2'b00};
      6'h04: return {BR, 2'b01};
      6'h05: return {BR | BN, 2'b01};
      6'h08: return {RW | AS, 2'b00};
      default: return 10'd0;
    endcase
  endfunction
  typedef struct {
    logic [31:0] instr, pc;
    logic valid, flush, wbw;
    logic [4:0] wba;
    logic [31:0] wbd;
    logic dbw;
    logic [4:0] dbwa;
    logic [31:0] dbwd;
    logic [4:0] dbra;
    logic [31:0] x_dbg;
    logic x_stall, x_valid;
    logic [31:0] x_d1, x_d2, x_sx;
    logic [4:0] x_rd;
    logic [7:0] x_ctrl;
    logic [1:0] x_alu;
  } vec_t;
  typedef struct {
    logic v;
    logic [31:0] pc, d1, d2, sx;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    logic [1:0] alu;
    logic [7:0] ctrl;
  } idex_t;
  vec_t tbl[10];
  idex_t e, n;
  logic [31:0] m_rf [32];
  task automatic check_e(input int c);
    chk($sformatf("c%0d o_valid", c), q_valid, e.v);
    chk($sformatf("c%0d o_pc", c), q_pc, e.pc);
    chk($sformatf("c%0d o_data_1", c), q_d1, e.d1);
    chk($sformatf("c%0d o_data_2", c), q_d2, e.d2);
    chk($sformatf("c%0d o_sign_extend", c), q_sx, e.sx);
    chk($sformatf("c%0d o_rs", c), q_rs, e.rs);
    chk($sformatf("c%0d o_rt", c), q_rt, e.rt);
    chk($sformatf("c%0d o_rd", c), q_rd, e.rd);
    chk($sformatf("c%0d o_funct", c), q_fn, e.fn);
    chk($sformatf("c%0d o_alu_op", c), q_alu, e.alu);
    chk($sformatf("c%0d o_ctrl", c), q_ctrl, e.ctrl);
  endtask
  initial begin
    logic [9:0] dc;
    logic ms, tk;
    logic [31:0] r1, r2, sx, tg;
    logic [5:0] op;
    tbl[0] = '{32'h0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{32'h0, 32'h0, 0, 0, 0, 0, 0, 1, 2, 8, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{32'h00221820, 32'h104, 1, 0, 0, 0, 0, 0, 0, 0, 2, 8, 0, 1, 7, 8, 32'h1820, 3, 8'h81, 2'b10};
    tbl[3] = '{32'h00803020, 32'h108, 1, 0, 1, 4, 32'h55, 0, 0, 0, 4, 0, 0, 1, 32'h55, 0, 32'h3020, 6, 8'h81, 2'b10};
    tbl[4] = '{32'h8C250000, 32'h10C, 1, 0, 0, 0, 0, 0, 0, 0, 4, 32'h55, 0, 1, 7, 0, 0, 0, 8'hE2, 2'b00};
    tbl[5] = '{32'h00A23020, 32'h110, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{32'h00A23020, 32'h110, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 8, 32'h3020, 6, 8'h81, 2'b10};
    tbl[7] = '{32'h8C250000, 32'h114, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 7, 0, 0, 0, 8'hE2, 2'b00};
    tbl[8] = '{32'h00A23020, 32'h118, 1, 1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[9] = '{32'h2027FFFC, 32'h11C, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 7, 0, 32'hFFFFFFFC, 31, 8'h82, 2'b00};
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset o_valid", q_valid, 0);
    chk("reset o_ctrl", q_ctrl, 0);
    chk("reset o_data_1", q_d1, 0);
    chk("reset o_pc", q_pc, 0);
    chk("reset o_stall", stall, 0);
    chk("reset debug read", dbg_q, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr = tbl[i].instr; pc = tbl[i].pc; valid = tbl[i].valid; flush = tbl[i].flush;
      wbw = tbl[i].wbw; wba = tbl[i].wba; wbd = tbl[i].wbd;
      dbw = tbl[i].dbw; dbwa = tbl[i].dbwa; dbwd = tbl[i].dbwd; dbra = tbl[i].dbra;
      #1;
      chk($sformatf("t%0d o_stall", i), stall, tbl[i].x_stall);
      chk($sformatf("t%0d debug read", i), dbg_q, tbl[i].x_dbg);
      tick();
      chk($sformatf("t%0d o_valid", i), q_valid, tbl[i].x_valid);
      chk($sformatf("t%0d o_data_1", i), q_d1, tbl[i].x_d1);
      chk($sformatf("t%0d o_data_2", i), q_d2, tbl[i].x_d2);
      chk($sformatf("t%0d o_sign_extend", i), q_sx, tbl[i].x_sx);
      chk($sformatf("t%0d o_rd", i), q_rd, tbl[i].x_rd);
      chk($sformatf("t%0d o_ctrl", i), q_ctrl, tbl[i].x_ctrl);
      chk($sformatf("t%0d o_alu_op", i), q_alu, tbl[i].x_alu);
    end
    idle();
    instr = 32'h00221820; valid = 1; halt = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("halt%0d o_valid", i), q_valid, 1);
      chk($sformatf("halt%0d o_data_1", i), q_d1, 7);
      chk($sformatf("halt%0d o_ctrl", i), q_ctrl, 8'h82);
      chk($sformatf("halt%0d o_sign_extend", i), q_sx, 32'hFFFFFFFC);
      chk($sformatf("halt%0d o_rd", i), q_rd, 31);
    end
    idle();
    instr = 32'h10210004; pc = 32'h10; valid = 1;
    #1;
`ifdef BRANCH_RESOLVE_EN
    chk("beq taken", b_taken, 1);
    chk("beq target", b_target, 32'h20);
`else
    chk("beq taken", b_taken, 0);
    chk("beq target", b_target, 0);
`endif
    tick();
`ifdef BRANCH_RESOLVE_EN
    chk("beq o_ctrl", q_ctrl, 8'h00);
`else
    chk("beq o_ctrl", q_ctrl, 8'h08);
`endif
    chk("beq o_alu_op", q_alu, 2'b01);
    instr = 32'h14210004;
    #1;
    chk("bne equal taken", b_taken, 0);
    tick();
    instr = 32'h08000040;
    #1;
`ifdef BRANCH_RESOLVE_EN
    chk("j taken", b_taken, 1);
    chk("j target", b_target, 32'h100);
`else
    chk("j taken", b_taken, 0);
`endif
    tick();
    chk("j o_ctrl", q_ctrl, 0);
    chk("j o_valid", q_valid, 1);
    instr = 32'h8C250000;
    tick();
    instr = 32'h00A23020;
    #1;
    chk("pre-reset o_stall", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset o_stall", stall, 0);
    chk("async reset o_valid", q_valid, 0);
    chk("async reset o_ctrl", q_ctrl, 0);
    chk("async reset o_data_1", q_d1, 0);
    chk("async reset o_pc", q_pc, 0);
    chk("async reset o_rt", q_rt, 0);
    idle();
    #2 rst_n = 1'b1;
    dbra = 1;
    #1;
    chk("r1 after reset", dbg_q, 0);
    dbw = 1; dbwa = 0; dbwd = 5; wbw = 1; wba = 0; wbd = 6;
    tick();
    idle();
    #1;
    chk("r0 write ignored", dbg_q, 0);
    dbw = 1; dbwa = 9; dbwd = 32'hAA; wbw = 1; wba = 9; wbd = 32'hBB;
    tick();
    dbw = 1; dbwa = 10; dbwd = 32'h10; wbw = 1; wba = 11; wbd = 32'h11; dbra = 9;
    #1;
    chk("debug beats wb", dbg_q, 32'hAA);
    tick();
    idle();
    dbra = 10;
    #1;
    chk("debug write r10", dbg_q, 32'h10);
    dbra = 11;
    #1;
    chk("wb write r11", dbg_q, 32'h11);
    foreach (m_rf[i]) m_rf[i] = '0;
    m_rf[9] = 32'hAA; m_rf[10] = 32'h10; m_rf[11] = 32'h11;
    e = '{default: '0};
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 7))
        0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2b; 3: op = 6'h04;
        4: op = 6'h05; 5: op = 6'h08; 6: op = 6'h02; default: op = 6'h0f;
      endcase
      instr = $urandom;
      instr[31:26] = op;
      instr[25:21] = 5'($urandom_range(0, 7));
      instr[20:16] = 5'($urandom_range(0, 7));
      pc = $urandom & 32'hFFFF_FFFC;
      valid = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 7) == 0;
      halt = $urandom_range(0, 15) == 0;
      wbw = $urandom_range(0, 1); wba = 5'($urandom_range(0, 7)); wbd = $urandom;
      dbw = $urandom_range(0, 3) == 0; dbwa = 5'($urandom_range(0, 7)); dbwd = $urandom;
      dbra = 5'($urandom_range(0, 15));
      #1;
      ms = valid && e.v && e.ctrl[5] && e.rt != 0 && !flush &&
           (e.rt == instr[25:21] || (e.rt == instr[20:16] && op inside {6'h00, 6'h2b, 6'h04, 6'h05}));
      chk($sformatf("c%0d o_stall", c), stall, ms);
      chk($sformatf("c%0d debug read", c), dbg_q, m_rf[dbra]);
      r1 = (wbw && wba != 0 && wba == instr[25:21]) ? wbd : m_rf[instr[25:21]];
      r2 = (wbw && wba != 0 && wba == instr[20:16]) ? wbd : m_rf[instr[20:16]];
      sx = 32'(signed'(instr[15:0]));
      dc = dec(op);
`ifdef BRANCH_RESOLVE_EN
      tk = valid && !ms && !flush && ((op == 6'h04 && r1 == r2) || (op == 6'h05 && r1 != r2) || op == 6'h02);
      tg = op == 6'h02 ? {pc[31:28], instr[25:0], 2'b00} : pc + sx * 4;
      chk($sformatf("c%0d branch taken", c), b_taken, tk);
      if (tk) chk($sformatf("c%0d branch target", c), b_target, tg);
      dc[5:4] = 2'b00;
`else
      tk = 1'b0;
      tg = '0;
      chk($sformatf("c%0d branch taken", c), b_taken, tk);
      chk($sformatf("c%0d branch target", c), b_target, tg);
`endif
      if (halt) n = e;
      else if (flush || ms || !valid) n = '{default: '0};
      else n = '{1'b1, pc, r1, r2, sx, instr[25:21], instr[20:16], instr[15:11], instr[5:0], dc[1:0], dc[9:2]};
      tick();
      e = n;
      if (wbw && wba != 0) m_rf[wba] = wbd;
      if (dbw && dbwa != 0) m_rf[dbwa] = dbwd;
      check_e(c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
